r_rom_backend: RTL and testbench
================================

# r_rom_backend

Backend half of the R-ROM path. Drains the 8-byte little-endian address packets that the TileLink-side ROM frontend pushes into the command FIFO, reads the addressed 8-byte doubleword from a byte-wide synchronous ROM, and pushes the 8 data bytes, LSB first, into the response FIFO. It sits between the two clock-domain-agnostic FIFOs and the ROM macro, and is the only producer of the response FIFO.

## Interface

- ROM_AW, 16, ROM byte-address width; ROM holds 2^ROM_AW bytes.
- clk  input  1  clock. One clock only.
- rst_n  input  1  reset; asynchronous, active-low.
- cmd_empty  input  1  command FIFO empty.
- cmd_rd_en  output  1  command FIFO pop; combinational.
- cmd_dout  input  8  command FIFO data; valid the cycle after cmd_rd_en.
- rsp_full  input  1  response FIFO full.
- rsp_wr_en  output  1  response FIFO push; registered.
- rsp_din  output  8  response FIFO data; registered.
- rom_en  output  1  ROM read strobe; combinational.
- rom_addr  output  ROM_AW  ROM byte address; combinational.
- rom_data  input  8  ROM data; valid the cycle after rom_en, held until the next rom_en.

## Operation

- States: S_IDLE, S_ADDR, S_FETCH, S_PUSH. State is held in a dff with reset value S_IDLE.
- S_IDLE: clear req_cnt, rx_cnt, and byte_off. When ~cmd_empty, go to S_ADDR.
- S_ADDR:
  - cmd_rd_en = ~cmd_empty & (req_cnt < 8).
  - Each pop increments req_cnt (4 bits). rd_q is set one cycle after each pop.
  - In a cycle with rd_q high, shift addr_buf <= {cmd_dout, addr_buf[63:8]} and increment rx_cnt.
  - The first byte received is addr[7:0]. After the 8th byte is captured, go to S_FETCH.
  - Never pop more than 8 bytes per packet, so the next packet stays in the FIFO.
- Range check: oor = |addr_buf[63:ROM_AW]. Bits addr_buf[2:0] are ignored, which aligns the access down to 8 bytes.
- S_FETCH:
  - rom_addr = {addr_buf[ROM_AW-1:3], byte_off}.
  - rom_en = ~oor.
  - Go to S_PUSH unconditionally.
- S_PUSH:
  - If ~rsp_full: next cycle rsp_wr_en=1 and rsp_din = oor ? 8'h00 : rom_data. Then byte_off++.
  - If byte_off was 7, go to S_IDLE; otherwise go to S_FETCH.
  - If rsp_full: stay in S_PUSH with no push. rom_data stays stable because rom_en is low.
- Out-of-range requests return exactly 8 zero bytes and perform no ROM access.
- Default every cycle: rsp_wr_en <= 0. rsp_din holds its last value.

## Timing

- Reset values: state=S_IDLE; rsp_wr_en=0, rsp_din=0; cmd_rd_en=0, rom_en=0, rom_addr=0. Internal counters, rd_q, and addr_buf are 0.
- Reset mid-packet aborts it. Any partially consumed command bytes are lost, and no partial response is completed. The FIFOs are reset by the same rst_n.
- Address phase: 8 consecutive pops when the FIFO stays non-empty. S_FETCH is entered 9 cycles after the first pop, because the last byte is captured one cycle after its pop.
- Data phase: at least 2 cycles per byte (FETCH, PUSH). Pushes are never back-to-back, so a registered push after seeing ~rsp_full cannot overflow the FIFO.
- Minimum latency from first cmd_rd_en to the 8th rsp_wr_en is 9 + 16 cycles.
- cmd_empty asserting mid-packet stalls S_ADDR with no pop. An in-flight byte (rd_q) is still captured.
- Back-to-back packets: S_IDLE costs exactly 1 cycle between packets.

## Structure

- Shared package / isa.vh holds:
  - the state encodings,
  - packet length constant 8 (PKT_BYTES),
  - ROM_AW default.
  These are shared with the frontend.
- Use the codebase dff for state, rd_q, and pipeline flags. The remaining logic is a single module with no further sub-module.

## Test plan

- Address 0x0000_0000_0000_0010; ROM[0x10..0x17]=0x11..0x88 -> rsp_din sequence 0x11,0x22,…,0x88; exactly 8 pushes; returns to S_IDLE.
- Address 0x...0013 (unaligned) -> same bytes as 0x10; rom_addr steps 0x10..0x17.
- Address 0x0000_0001_0000_0000 with ROM_AW=16 -> 8 pushes of 0x00; rom_en never asserted.
- cmd_empty toggled every other cycle during the address bytes -> correct address assembled; exactly 8 pops.
- rsp_full held for 5 cycles at byte 3 -> no push while full, byte 3 value unchanged after release, total 8 pushes.
- Two packets queued back-to-back, then rst_n pulsed low during the second packet's data phase -> all outputs 0 immediately; the first response is complete; the second is truncated; the block resumes from S_IDLE.

Source files
------------

// File: rtl/r_rom_backend_pkg.sv
// Shared definitions for the R-ROM path: backend FSM encodings, packet length
// and the default ROM address width used by both frontend and backend.
package r_rom_backend_pkg;

    localparam int PKT_BYTES  = 8;
    localparam int ROM_AW_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_FETCH = 2'd2,
        S_PUSH  = 2'd3
    } state_t;

endpackage

// File: rtl/r_rom_backend_if.sv
// Command FIFO, response FIFO and ROM port bundle seen by the R-ROM backend.
// master = backend side, slave = FIFOs/ROM side.
interface r_rom_backend_if
    import r_rom_backend_pkg::*;
#(
    parameter int ROM_AW = ROM_AW_DEF
);
    logic              cmd_empty;
    logic              cmd_rd_en;
    logic [7:0]        cmd_dout;
    logic              rsp_full;
    logic              rsp_wr_en;
    logic [7:0]        rsp_din;
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;

    modport master (
        input  cmd_empty, cmd_dout, rsp_full, rom_data,
        output cmd_rd_en, rsp_wr_en, rsp_din, rom_en, rom_addr
    );

    modport slave (
        output cmd_empty, cmd_dout, rsp_full, rom_data,
        input  cmd_rd_en, rsp_wr_en, rsp_din, rom_en, rom_addr
    );
endinterface

// File: rtl/r_rom_backend_dff.sv
// Codebase flop: parameterised width and reset value, async active-low reset.
module r_rom_backend_dff #(
    parameter int             W   = 1,
    parameter logic [W-1:0]   RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its sources, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RST;
        else        q <= d;
    end
endmodule

// File: rtl/r_rom_backend.sv
// R-ROM backend: pops an 8-byte LE address packet, reads the aligned doubleword
// from the byte-wide sync ROM and pushes the 8 bytes LSB first to the response FIFO.
module r_rom_backend
    import r_rom_backend_pkg::*;
#(
    parameter int ROM_AW = ROM_AW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    r_rom_backend_if.master       bus
);
    logic [1:0]  state_q;
    state_t      state, state_nxt;
    logic        rd_q;
    logic        pop, push;
    logic        rsp_wr_en_q;
    logic [7:0]  rsp_din_q;
    logic [3:0]  req_cnt, rx_cnt;
    logic [2:0]  byte_off;
    logic [63:3] addr_buf;   // bits [2:0] are never stored: access aligns down to 8 bytes
    logic        oor;
    logic        last_rx;
    logic        rom_en;
    logic [ROM_AW-1:0] rom_addr;

    r_rom_backend_dff #(.W(2), .RST(S_IDLE)) u_state (
        .clk(clk), .rst_n(rst_n), .d(state_nxt), .q(state_q));
    r_rom_backend_dff #(.W(1)) u_rd_q (
        .clk(clk), .rst_n(rst_n), .d(pop), .q(rd_q));
    r_rom_backend_dff #(.W(1)) u_wr_en (
        .clk(clk), .rst_n(rst_n), .d(push), .q(rsp_wr_en_q));

    assign state   = state_t'(state_q);
    assign oor     = |addr_buf[63:ROM_AW];
    assign last_rx = rd_q && (rx_cnt == 4'(PKT_BYTES - 1));

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        push      = 1'b0;
        rom_en    = 1'b0;
        rom_addr  = '0;
        case (state)
            S_IDLE:  if (!bus.cmd_empty) state_nxt = S_ADDR;
            S_ADDR: begin
                // Never pop beyond one packet so the next one stays queued.
                pop = !bus.cmd_empty && (req_cnt < 4'(PKT_BYTES));
                if (last_rx) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                rom_en    = !oor;
                rom_addr  = {addr_buf[ROM_AW-1:3], byte_off};
                state_nxt = S_PUSH;
            end
            S_PUSH: begin
                if (!bus.rsp_full) begin
                    push      = 1'b1;
                    state_nxt = (byte_off == 3'd7) ? S_IDLE : S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt   <= '0;
            rx_cnt    <= '0;
            byte_off  <= '0;
            addr_buf  <= '0;
            rsp_din_q <= '0;
        end else begin
            if (state == S_IDLE) begin
                req_cnt  <= '0;
                rx_cnt   <= '0;
                byte_off <= '0;
            end else begin
                if (pop)  req_cnt <= req_cnt + 4'd1;
                if (rd_q) begin
                    addr_buf <= {bus.cmd_dout, addr_buf[63:11]};
                    rx_cnt   <= rx_cnt + 4'd1;
                end
                if (push) byte_off <= byte_off + 3'd1;
            end
            // rom_data is still valid here: rom_en stays low while stalled in S_PUSH.
            if (push) rsp_din_q <= oor ? 8'h00 : bus.rom_data;
        end
    end

    assign bus.cmd_rd_en = pop;
    assign bus.rom_en    = rom_en;
    assign bus.rom_addr  = rom_addr;
    assign bus.rsp_wr_en = rsp_wr_en_q;
    assign bus.rsp_din   = rsp_din_q;
endmodule

// File: tb/tb_r_rom_backend.sv
// Self-checking bench for r_rom_backend: FIFO/ROM models, scoreboard of
// expected response bytes, table of address vectors plus hand-written corner cases.
module tb_r_rom_backend;
    import r_rom_backend_pkg::*;

    localparam int AW = ROM_AW_DEF;

    typedef struct {
        logic [63:0] addr;
        int          exp_reads;
        logic [15:0] exp_base;
        int          exp_latency;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    r_rom_backend_if #(.ROM_AW(AW)) bus ();
    r_rom_backend #(.ROM_AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0]    rom [0:(1<<AW)-1];
    logic [7:0]    cmd_q[$];
    logic [7:0]    exp_q[$];
    logic [AW-1:0] rd_addr_q[$];
    logic          gate = 1'b0;
    int n_checks = 0, n_fail = 0;
    int cyc = 0, n_push = 0, n_pop = 0;
    int first_pop_cyc = -1, last_push_cyc = -1;
    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [63:0] a, input int i);
        logic [AW-1:0] base;
        if ((a >> AW) != 64'd0) return 8'h00;
        base = {a[AW-1:3], 3'b000};
        return rom[int'(base) + i];
    endfunction

    // One clock: FIFO/ROM models react to the edge, response pushes are scored.
    task automatic tick();
        logic          popped, empty_pre, romrd;
        logic [AW-1:0] ra;
        popped    = bus.cmd_rd_en;
        empty_pre = bus.cmd_empty;
        romrd     = bus.rom_en;
        ra        = bus.rom_addr;
        if (popped) check("pop_while_empty", empty_pre, 1'b0);
        @(posedge clk);
        #1;
        cyc++;
        if (popped) begin
            if (cmd_q.size() > 0) bus.cmd_dout = cmd_q.pop_front();
            n_pop++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc - 1;
        end
        if (romrd) begin
            bus.rom_data = rom[ra];
            rd_addr_q.push_back(ra);
        end
        bus.cmd_empty = (cmd_q.size() == 0) || gate;
        if (bus.rsp_wr_en) begin
            n_push++;
            last_push_cyc = cyc;
            check("scoreboard_nonempty_on_push", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("rsp_din", bus.rsp_din, exp_q.pop_front());
        end
        #1;
    endtask

    task automatic queue_pkt(input logic [63:0] addr);
        for (int i = 0; i < PKT_BYTES; i++) begin
            cmd_q.push_back(addr[8*i +: 8]);
            exp_q.push_back(model_byte(addr, i));
        end
        bus.cmd_empty = (cmd_q.size() == 0) || gate;
        #1;
    endtask

    task automatic wait_pushes(input int target, input int budget);
        int n = 0;
        while (n_push < target && n < budget) begin
            tick();
            n++;
        end
        check("push_count_within_budget", n_push, target);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rsp_wr_en"}, bus.rsp_wr_en, 1'b0);
        check({tag, "_rsp_din"},   bus.rsp_din,   8'h00);
        check({tag, "_cmd_rd_en"}, bus.cmd_rd_en, 1'b0);
        check({tag, "_rom_en"},    bus.rom_en,    1'b0);
        check({tag, "_rom_addr"},  bus.rom_addr,  '0);
        check({tag, "_state"},     dut.state,     S_IDLE);
    endtask

    task automatic run_vec(input vec_t v);
        int q0, pop0;
        q0 = n_push;
        pop0 = n_pop;
        rd_addr_q.delete();
        first_pop_cyc = -1;
        queue_pkt(v.addr);
        wait_pushes(q0 + PKT_BYTES, 200);
        check("end_state_idle", dut.state, S_IDLE);
        check("pops_per_packet", n_pop - pop0, PKT_BYTES);
        check("latency", last_push_cyc - first_pop_cyc, v.exp_latency);
        check("rom_reads", rd_addr_q.size(), v.exp_reads);
        for (int i = 0; i < rd_addr_q.size(); i++)
            check("rom_addr", rd_addr_q[i], v.exp_base + 16'(i));
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (3) tick();
        check("no_extra_push", n_push, q0 + PKT_BYTES);
    endtask

    initial begin
        int q0, pop0, c1;

        for (int i = 0; i < (1 << AW); i++) rom[i] = 8'(i) ^ 8'(i >> 8) ^ 8'hA5;
        for (int i = 0; i < 8; i++) rom[16 + i] = 8'(8'h11 * (i + 1));

        vecs[0] = '{64'h0000_0000_0000_0010, 8, 16'h0010, 25};
        vecs[1] = '{64'h0000_0000_0000_0013, 8, 16'h0010, 25};
        vecs[2] = '{64'h0000_0001_0000_0000, 0, 16'h0000, 25};
        vecs[3] = '{64'h0000_0000_0000_FFFF, 8, 16'hFFF8, 25};
        vecs[4] = '{64'h0000_0000_0001_0000, 0, 16'h0000, 25};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 0, 16'h0000, 25};
        vecs[6] = '{64'h0000_0000_0000_1238, 8, 16'h1238, 25};

        bus.cmd_empty = 1'b1;
        bus.cmd_dout  = 8'h00;
        bus.rsp_full  = 1'b0;
        bus.rom_data  = 8'h00;

        #1 rst_n = 1'b0;
        #2 check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // cmd_empty toggling every cycle during the address phase
        q0 = n_push; pop0 = n_pop; rd_addr_q.delete();
        gate = 1'b1;
        queue_pkt(64'h0000_0000_0000_2468);
        for (int n = 0; n < 100 && (n_pop - pop0) < PKT_BYTES; n++) begin
            gate = ~gate;
            tick();
        end
        gate = 1'b0;
        wait_pushes(q0 + PKT_BYTES, 100);
        check("toggle_pops", n_pop - pop0, PKT_BYTES);
        check("toggle_rom_base", (rd_addr_q.size() > 0) ? rd_addr_q[0] : '1, 16'h2468);
        check("toggle_scoreboard_drained", exp_q.size(), 0);

        // rsp_full held for 5 cycles at byte 3
        q0 = n_push;
        queue_pkt(64'h0000_0000_0000_0010);
        wait_pushes(q0 + 3, 100);
        bus.rsp_full = 1'b1;
        repeat (5) begin
            tick();
            check("no_push_while_full", bus.rsp_wr_en, 1'b0);
        end
        check("rsp_din_held_while_full", bus.rsp_din, 8'h33);
        bus.rsp_full = 1'b0;
        wait_pushes(q0 + PKT_BYTES, 100);
        repeat (3) tick();
        check("stall_total_pushes", n_push, q0 + PKT_BYTES);

        // back-to-back packets, then reset during the second data phase
        q0 = n_push; pop0 = n_pop; first_pop_cyc = -1;
        queue_pkt(64'h0000_0000_0000_0010);
        queue_pkt(64'h0000_0000_0000_1238);
        wait_pushes(q0 + PKT_BYTES, 200);
        check("b2b_first_pops", n_pop - pop0, PKT_BYTES);
        check("b2b_idle_after_first", dut.state, S_IDLE);
        c1 = last_push_cyc;
        first_pop_cyc = -1;
        tick();
        tick();
        check("b2b_idle_gap", first_pop_cyc - c1, 1);
        wait_pushes(q0 + PKT_BYTES + 3, 200);
        check("b2b_second_pops", n_pop - pop0, 2 * PKT_BYTES);
        rst_n = 1'b0;
        #1 check_outputs_zero("midreset");
        cmd_q.delete();
        exp_q.delete();
        bus.cmd_empty = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        q0 = n_push; pop0 = n_pop;
        repeat (5) tick();
        check("truncated_no_push", n_push, q0);
        check("truncated_no_pop", n_pop, pop0);
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
